// File: rtl/adder9_seq_ctrl.sv
// rtl/adder9_seq_ctrl.sv - wide adder sequencer driving one shared 9-bit adder slice per clock
// Optional feature macro: ADDER9_SEQ_SUB_EN (adds a sub input; A-B via inverted B and forced carry-in)
module adder9_seq_ctrl #(
   parameter int NSLICES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [9*NSLICES-1:0]   a,
   input  logic [9*NSLICES-1:0]   b,
   input  logic                   cin,
`ifdef ADDER9_SEQ_SUB_EN
   input  logic                   sub,
`endif
   output logic                   busy,
   output logic                   done,
   output logic [9*NSLICES-1:0]   sum,
   output logic                   cout,
   output logic [8:0]             add_a,
   output logic [8:0]             add_b,
   output logic                   add_cin,
   input  logic [8:0]             add_s,
   input  logic                   add_cout
);

   localparam int W  = 9 * NSLICES;
   localparam int IW = (NSLICES > 1) ? $clog2(NSLICES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
`ifdef ADDER9_SEQ_SUB_EN
   logic            sub_q, sub_d;
`endif

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

   // Select the active slice for the shared adder; drive zeros whenever not running
   always_comb begin
      add_a   = 9'd0;
      add_b   = 9'd0;
      add_cin = 1'b0;
      if (state_q == RUN) begin
         add_cin = carry_q;
         for (int k = 0; k < NSLICES; k++) begin
            if (idx_q == IW'(k)) begin
               add_a = a_q[9*k +: 9];
`ifdef ADDER9_SEQ_SUB_EN
               add_b = sub_q ? ~b_q[9*k +: 9] : b_q[9*k +: 9];
`else
               add_b = b_q[9*k +: 9];
`endif
            end
         end
      end
   end

   // Next-state and datapath updates: accept in IDLE/DONE, one slice per RUN cycle
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef ADDER9_SEQ_SUB_EN
      sub_d   = sub_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sum_d   = '0;
               cout_d  = 1'b0;
               idx_d   = '0;
`ifdef ADDER9_SEQ_SUB_EN
               sub_d   = sub;
               carry_d = sub | cin;
`else
               carry_d = cin;
`endif
               state_d = RUN;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            for (int k = 0; k < NSLICES; k++) begin
               if (idx_q == IW'(k)) begin
                  sum_d[9*k +: 9] = add_s;
               end
            end
            carry_d = add_cout;
            if (idx_q == IW'(NSLICES - 1)) begin
               cout_d  = add_cout;
               idx_d   = '0;
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + 1'b1;
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Single state register for FSM, operands, result and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef ADDER9_SEQ_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef ADDER9_SEQ_SUB_EN
         sub_q   <= sub_d;
`endif
      end
   end

endmodule

// File: tb/tb_adder9_seq_ctrl.sv
// tb/tb_adder9_seq_ctrl.sv - randomized self-checking bench for adder9_seq_ctrl
module tb_adder9_seq_ctrl;

   localparam int NS = 4;
   localparam int W  = 9 * NS;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           cin = 1'b0;
`ifdef ADDER9_SEQ_SUB_EN
   logic           sub = 1'b0;
`endif
   logic           busy, done, cout;
   logic [W-1:0]   sum;
   logic [8:0]     add_a, add_b, add_s;
   logic           add_cin, add_cout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Shared combinational 9-bit adder slice outside the sequencer
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {9'd0, add_cin};

   adder9_seq_ctrl #(.NSLICES(NS)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
`ifdef ADDER9_SEQ_SUB_EN
      .sub      (sub),
`endif
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_s    (add_s),
      .add_cout (add_cout)
   );

   function automatic logic [W-1:0] rnd();
      return W'({$urandom(), $urandom()});
   endfunction

   // Reference: plain wide arithmetic on the operands
   function automatic logic [W:0] model_add(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
      return {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
   endfunction

   // Issue one request and observe it until done (bounded); operands scrambled after acceptance
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                        output logic [W-1:0] osum, output logic ocout, output int olat,
                        output int obusy, output logic [7:0] otrace);
      osum = '0; ocout = 1'b0; olat = -1; obusy = 0; otrace = '0;
      @(negedge clk);
      a = ta; b = tb; cin = tcin; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = rnd(); b = rnd(); cin = 1'($urandom_range(0, 1));
      for (int c = 1; c <= 20; c++) begin
         if (done) begin
            olat = c; osum = sum; ocout = cout;
            break;
         end
         if (busy) begin
            if (obusy < 8) otrace[obusy[2:0]] = add_cin;
            obusy++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
      checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%0b exp=0", cout); end
      checks++; if (add_a !== 9'd0 || add_b !== 9'd0 || add_cin !== 1'b0) begin
         errors++; $display("FAIL reset_adder_drive got=%h/%h/%0b exp=0/0/0", add_a, add_b, add_cin);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle got busy=%0b done=%0b exp=0/0", busy, done);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] s; logic co; int lat, nb; logic [7:0] tr;
      do_op(36'd1, 36'd1, 1'b0, s, co, lat, nb, tr);
      checks++; if (lat !== NS + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, NS + 1); end
      checks++; if (nb !== NS) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", nb, NS); end
      checks++; if (s !== 36'h0_0000_0002 || co !== 1'b0) begin
         errors++; $display("FAIL basic_sum got=%h/%0b exp=2/0", s, co);
      end
   endtask

   task automatic test_carry_ripple();
      logic [W-1:0] s; logic co; int lat, nb; logic [7:0] tr;
      do_op(36'hF_FFFF_FFFF, 36'd0, 1'b1, s, co, lat, nb, tr);
      checks++; if (s !== '0 || co !== 1'b1) begin errors++; $display("FAIL ripple_sum got=%h/%0b exp=0/1", s, co); end
      checks++; if (tr[NS-1:0] !== 4'b1111) begin errors++; $display("FAIL ripple_add_cin got=%b exp=1111", tr[NS-1:0]); end
   endtask

   task automatic test_random();
      logic [W-1:0] s, ra, rb; logic co, rc; int lat, nb; logic [7:0] tr; logic [W:0] exp_v;
      for (int i = 0; i < 20; i++) begin
         ra = rnd(); rb = rnd(); rc = 1'($urandom_range(0, 1));
         if (i == 0) begin ra = '1; rb = '1; rc = 1'b1; end
         exp_v = model_add(ra, rb, rc);
         do_op(ra, rb, rc, s, co, lat, nb, tr);
         checks++; if ({co, s} !== exp_v || lat !== NS + 1) begin
            errors++;
            $display("FAIL random_add[%0d] got=%0b_%h lat=%0d exp=%0b_%h lat=%0d", i, co, s, lat, exp_v[W], exp_v[W-1:0], NS + 1);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int ndone = 0; int first = -1; logic [W-1:0] s = '0;
      @(negedge clk); a = 36'd3; b = 36'd4; cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; a = 36'd100; b = 36'd100;
      @(negedge clk); start = 1'b0;
      for (int c = 3; c <= 15; c++) begin
         if (done) begin ndone++; if (first < 0) begin first = c; s = sum; end end
         @(negedge clk);
      end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_done_count got=%0d exp=1", ndone); end
      checks++; if (first !== NS + 1 || s !== 36'd7) begin
         errors++; $display("FAIL busy_start_sum got=%h at=%0d exp=7 at=%0d", s, first, NS + 1);
      end
   endtask

   task automatic test_reset_mid_run();
      int ndone = 0; logic [W-1:0] s; logic co; int lat, nb; logic [7:0] tr;
      @(negedge clk); a = 36'h1FF; b = 36'd1; cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy_before got=%0b exp=1", busy); end
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
         errors++; $display("FAIL midrun_reset got busy=%0b done=%0b sum=%h cout=%0b exp=0/0/0/0", busy, done, sum, cout);
      end
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (done || busy) ndone++;
         @(negedge clk);
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL midrun_no_done got=%0d exp=0", ndone); end
      do_op(36'd2, 36'd2, 1'b0, s, co, lat, nb, tr);
      checks++; if (s !== 36'd4 || co !== 1'b0 || lat !== NS + 1) begin
         errors++; $display("FAIL midrun_after got=%h/%0b lat=%0d exp=4/0 lat=%0d", s, co, lat, NS + 1);
      end
   endtask

   task automatic test_back_to_back();
      int ndone = 0; int at = -1; logic [W-1:0] s = '0;
      @(negedge clk); a = 36'd5; b = 36'd6; cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (NS - 1) @(negedge clk);
      start = 1'b1; a = 36'd10; b = 36'd20;
      @(negedge clk);
      checks++; if (done !== 1'b1 || sum !== 36'd11) begin
         errors++; $display("FAIL b2b_first got done=%0b sum=%h exp=1/11", done, sum);
      end
      @(negedge clk); start = 1'b0;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL b2b_accept got busy=%0b done=%0b exp=1/0", busy, done);
      end
      for (int c = NS + 2; c <= NS + 12; c++) begin
         if (done) begin ndone++; if (at < 0) begin at = c; s = sum; end end
         @(negedge clk);
      end
      checks++; if (ndone !== 1 || at !== 2 * NS + 2 || s !== 36'd30) begin
         errors++; $display("FAIL b2b_second got n=%0d at=%0d sum=%h exp=1/%0d/30", ndone, at, s, 2 * NS + 2);
      end
   endtask

`ifdef ADDER9_SEQ_SUB_EN
   task automatic test_sub();
      logic [W-1:0] s, ra, rb; logic co; int lat, nb; logic [7:0] tr;
      logic [W-1:0] exp_s; logic exp_c; logic ds;
      sub = 1'b1;
      do_op(36'd5, 36'd7, 1'b0, s, co, lat, nb, tr);
      checks++; if (s !== 36'hF_FFFF_FFFE || co !== 1'b0) begin
         errors++; $display("FAIL sub_5_7 got=%h/%0b exp=ffffffffe/0", s, co);
      end
      do_op(36'd7, 36'd5, 1'b0, s, co, lat, nb, tr);
      checks++; if (s !== 36'd2 || co !== 1'b1) begin
         errors++; $display("FAIL sub_7_5 got=%h/%0b exp=2/1", s, co);
      end
      for (int i = 0; i < 10; i++) begin
         ra = rnd(); rb = rnd(); ds = 1'($urandom_range(0, 1));
         sub = ds;
         if (ds) begin exp_s = ra - rb; exp_c = (ra >= rb); end
         else begin {exp_c, exp_s} = model_add(ra, rb, 1'b0); end
         do_op(ra, rb, 1'b0, s, co, lat, nb, tr);
         checks++; if (s !== exp_s || co !== exp_c) begin
            errors++; $display("FAIL sub_random[%0d] sub=%0b got=%h/%0b exp=%h/%0b", i, ds, s, co, exp_s, exp_c);
         end
      end
      sub = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_carry_ripple();
      test_random();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
`ifdef ADDER9_SEQ_SUB_EN
      test_sub();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
